// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: FSM encoding, port ids,
// transaction fields and the legal data window used by DATA_ARB_RANGE_CHECK_EN.
package data_memory_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int FMT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_SEC  = 1'b1;

    localparam logic [ADDR_W-1:0] DATA_BEGIN = 32'h0000_1000;
    localparam logic [ADDR_W-1:0] DATA_END   = 32'h0000_FFFF;

    typedef struct packed {
        logic              write;
        logic [FMT_W-1:0]  format;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic logic in_data_range(input logic [ADDR_W-1:0] addr);
        return (addr >= DATA_BEGIN) && (addr <= DATA_END);
    endfunction

endpackage

// File: rtl/data_memory_arbiter_select.sv
// Purpose: fixed-priority (port 0 first) grant with port-1 starvation override.
// Latency: purely combinational; the caller registers grant and counter.
// Backpressure: none; the caller only samples the result while idle.
module data_arbiter_select
    import data_memory_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             p0_req,
    input  logic             p1_req,
    input  logic [CNT_W-1:0] cnt,
    output logic             grant_vld,
    output logic             grant_id,
    output logic [CNT_W-1:0] cnt_next
);

    logic cnt_limit;

    assign cnt_limit = (cnt == CNT_W'(MAX_BURST));
    assign grant_vld = p0_req | p1_req;

    always_comb begin
        grant_id = PORT_CORE;
        cnt_next = '0;
        if (p1_req && (cnt_limit || !p0_req)) begin
            grant_id = PORT_SEC;
            cnt_next = '0;
        end else if (p0_req) begin
            grant_id = PORT_CORE;
            // Only grants that make port 1 wait count toward starvation.
            if (p1_req) begin
                cnt_next = cnt_limit ? cnt : cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Purpose: two-port arbiter onto one data memory interface; DATA_ARB_RANGE_CHECK_EN adds window check.
// Latency: 3 cycles IDLE sample -> ACCESS -> RESP (ready pulse), one transaction per 3 cycles.
// Backpressure: requesters hold req and fields until their one-cycle ready pulse.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_write,
    input  logic [FMT_W-1:0]  p0_format,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_error,

    input  logic              p1_req,
    input  logic              p1_write,
    input  logic [FMT_W-1:0]  p1_format,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_error,

    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [FMT_W-1:0]  mem_format,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_req_t          lat_q, lat_d;
    logic              port_q, port_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

    mem_req_t          p0_fields, p1_fields, win_req;
    logic              grant_vld, grant_id;
    logic [CNT_W-1:0]  cnt_next;
    logic              range_err;

    assign p0_fields = '{write: p0_write, format: p0_format, address: p0_address, wdata: p0_wdata};
    assign p1_fields = '{write: p1_write, format: p1_format, address: p1_address, wdata: p1_wdata};
    assign win_req   = (grant_id == PORT_SEC) ? p1_fields : p0_fields;

    data_arbiter_select #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_select (
        .p0_req    (p0_req),
        .p1_req    (p1_req),
        .cnt       (cnt_q),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .cnt_next  (cnt_next)
    );

`ifdef DATA_ARB_RANGE_CHECK_EN
    assign range_err = !in_data_range(win_req.address);
`else
    assign range_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lat_q      <= '0;
            port_q     <= PORT_CORE;
            err_q      <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            port_q     <= port_d;
            err_q      <= err_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (grant_vld) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        port_d     = port_q;
        err_d      = err_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;

        // Every idle cycle is an arbitration point, so the counter tracks p1_req there.
        if (state_q == ST_IDLE) begin
            cnt_d = cnt_next;
            if (grant_vld) begin
                lat_d  = win_req;
                port_d = grant_id;
                err_d  = range_err;
            end
        end

        if ((state_q == ST_ACCESS) && !lat_q.write && !err_q) begin
            if (port_q == PORT_SEC) begin
                p1_rdata_d = mem_rdata;
            end else begin
                p0_rdata_d = mem_rdata;
            end
        end
    end

    always_comb begin
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        p0_ready         = 1'b0;
        p1_ready         = 1'b0;
        p0_error         = 1'b0;
        p1_error         = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                if (!err_q) begin
                    mem_write_enable = lat_q.write;
                    mem_read_enable  = !lat_q.write;
                end
            end
            ST_RESP: begin
                if (port_q == PORT_SEC) begin
                    p1_ready = 1'b1;
                    p1_error = err_q;
                end else begin
                    p0_ready = 1'b1;
                    p0_error = err_q;
                end
            end
            default: ;
        endcase
    end

    assign mem_format  = lat_q.format;
    assign mem_address = lat_q.address;
    assign mem_wdata   = lat_q.wdata;
    assign p0_rdata    = p0_rdata_q;
    assign p1_rdata    = p1_rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus random traffic against a
// transaction-level model (pending requests per port, shadow memory, starvation count).
module tb_data_memory_arbiter;

    localparam int MAX_BURST = 4;

    logic        clock;
    logic        reset;
    logic        p0_req, p0_write, p0_ready, p0_error;
    logic [2:0]  p0_format;
    logic [31:0] p0_address, p0_wdata, p0_rdata;
    logic        p1_req, p1_write, p1_ready, p1_error;
    logic [2:0]  p1_format;
    logic [31:0] p1_address, p1_wdata, p1_rdata;
    logic        mem_read_enable, mem_write_enable;
    logic [2:0]  mem_format;
    logic [31:0] mem_address, mem_wdata, mem_rdata;

    data_memory_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clock            (clock),
        .reset            (reset),
        .p0_req           (p0_req),
        .p0_write         (p0_write),
        .p0_format        (p0_format),
        .p0_address       (p0_address),
        .p0_wdata         (p0_wdata),
        .p0_ready         (p0_ready),
        .p0_rdata         (p0_rdata),
        .p0_error         (p0_error),
        .p1_req           (p1_req),
        .p1_write         (p1_write),
        .p1_format        (p1_format),
        .p1_address       (p1_address),
        .p1_wdata         (p1_wdata),
        .p1_ready         (p1_ready),
        .p1_rdata         (p1_rdata),
        .p1_error         (p1_error),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_format       (mem_format),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cycle_cnt;
    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    // Memory-side model: 64 words behind address bits [7:2], preloadable from the bench.
    logic [31:0] mem_array [64];
    logic        ld_vld;
    logic [5:0]  ld_idx;
    logic [31:0] ld_dat;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] off,
                                          input logic [2:0] fmt, input logic [31:0] wdat);
        logic [31:0] w;
        w = old;
        case (fmt[1:0])
            2'b00:   w[8*off +: 8] = wdat[7:0];
            2'b01:   w[16*off[1] +: 16] = wdat[15:0];
            default: w = wdat;
        endcase
        return w;
    endfunction

    always_comb mem_rdata = mem_read_enable ? mem_array[mem_address[7:2]] : 32'hBAD0_BAD0;

    always @(posedge clock) begin
        if (ld_vld)
            mem_array[ld_idx] <= ld_dat;
        else if (mem_write_enable)
            mem_array[mem_address[7:2]] <= merge(mem_array[mem_address[7:2]], mem_address[1:0],
                                                 mem_format, mem_wdata);
    end

    // Reference model state
    bit          pend [2];
    bit          wr   [2];
    logic [2:0]  fmt  [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_rdata [2];
    int          ref_cnt;
    int          last_ready_cycle [2];
    int          exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    int n_checks, n_pass, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic apply_inputs();
        p0_req = pend[0]; p0_write = wr[0]; p0_format = fmt[0]; p0_address = addr[0]; p0_wdata = wd[0];
        p1_req = pend[1]; p1_write = wr[1]; p1_format = fmt[1]; p1_address = addr[1]; p1_wdata = wd[1];
    endtask

    task automatic new_txn(input int p);
        int sel;
        wr[p] = 1'($urandom_range(0, 1));
        if (wr[p]) begin
            fmt[p] = 3'($urandom_range(0, 2));
        end else begin
            sel    = $urandom_range(0, 4);
            fmt[p] = (sel > 2) ? 3'(sel + 1) : 3'(sel);
        end
        addr[p] = 32'h0000_2000 | 32'($urandom_range(0, 255));
        if (fmt[p][1:0] == 2'b01) addr[p][0] = 1'b0;
        if (fmt[p][1:0] == 2'b10) addr[p][1:0] = 2'b00;
        wd[p]   = $urandom;
        pend[p] = 1'b1;
    endtask

    // Called at the falling edge of an idle cycle with the requests already applied;
    // returns at the falling edge of the next idle cycle.
    task automatic run_slot(output int obs_winner);
        int         w;
        logic [1:0] rdy;
        chk("idle_p0_ready", p0_ready, 0);
        chk("idle_p1_ready", p1_ready, 0);
        chk("idle_rd_en", mem_read_enable, 0);
        chk("idle_wr_en", mem_write_enable, 0);
        obs_winner = -1;
        if (!pend[0] && !pend[1]) begin
            @(negedge clock);
            return;
        end
        if (pend[1] && (ref_cnt == MAX_BURST || !pend[0])) begin
            w = 1;
            ref_cnt = 0;
        end else begin
            w = 0;
            ref_cnt = pend[1] ? ((ref_cnt + 1 > MAX_BURST) ? MAX_BURST : ref_cnt + 1) : 0;
        end
        @(negedge clock);
        chk("access_rd_en", mem_read_enable, 32'(!wr[w]));
        chk("access_wr_en", mem_write_enable, 32'(wr[w]));
        chk("access_addr", mem_address, addr[w]);
        chk("access_fmt", mem_format, fmt[w]);
        chk("access_wdata", mem_wdata, wd[w]);
        chk("access_no_ready", p0_ready | p1_ready, 0);
        @(negedge clock);
        if (wr[w])
            ref_mem[addr[w][7:2]] = merge(ref_mem[addr[w][7:2]], addr[w][1:0], fmt[w], wd[w]);
        else
            exp_rdata[w] = ref_mem[addr[w][7:2]];
        rdy = {p1_ready, p0_ready};
        chk("resp_winner_ready", rdy[w], 1);
        chk("resp_loser_ready", rdy[1-w], 0);
        chk("resp_rd_en", mem_read_enable, 0);
        chk("resp_wr_en", mem_write_enable, 0);
        chk("resp_p0_rdata", p0_rdata, exp_rdata[0]);
        chk("resp_p1_rdata", p1_rdata, exp_rdata[1]);
        chk("resp_errors", {p1_error, p0_error}, 0);
        obs_winner = p1_ready ? 1 : (p0_ready ? 0 : -1);
        last_ready_cycle[w] = cycle_cnt;
        pend[w] = 1'b0;
        apply_inputs();
        @(negedge clock);
    endtask

    task automatic drain();
        int ow;
        for (int k = 0; k < 8 && (pend[0] || pend[1]); k++) run_slot(ow);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ow;
        n_checks = 0; n_pass = 0; n_fail = 0;
        ref_cnt = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; wr[p] = 1'b0; fmt[p] = 3'b000; addr[p] = '0; wd[p] = '0;
            exp_rdata[p] = '0; last_ready_cycle[p] = 0;
        end
        reset = 1'b1;
        ld_vld = 1'b0; ld_idx = '0; ld_dat = '0;
        apply_inputs();
        repeat (2) @(negedge clock);
        for (int i = 0; i < 64; i++) begin
            ld_vld = 1'b1;
            ld_idx = 6'(i);
            ld_dat = (i == 1) ? 32'hDEAD_BEEF : $urandom;
            ref_mem[i] = ld_dat;
            @(negedge clock);
        end
        ld_vld = 1'b0;

        // Reset state
        chk("rst_ready", {p1_ready, p0_ready}, 0);
        chk("rst_error", {p1_error, p0_error}, 0);
        chk("rst_enables", {mem_write_enable, mem_read_enable}, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_fmt", mem_format, 0);
        reset = 1'b0;
        @(negedge clock);

        // Single p0 word read
        pend[0] = 1'b1; wr[0] = 1'b0; fmt[0] = 3'b010; addr[0] = 32'h0000_2004; wd[0] = $urandom;
        apply_inputs();
        run_slot(ow);
        chk("p0_read_winner", 32'(ow), 0);
        chk("p0_read_data", p0_rdata, 32'hDEAD_BEEF);

        // Simultaneous requests: p0 first, p1 three cycles later
        pend[0] = 1'b1; wr[0] = 1'b0; fmt[0] = 3'b010; addr[0] = 32'h0000_2010;
        pend[1] = 1'b1; wr[1] = 1'b0; fmt[1] = 3'b010; addr[1] = 32'h0000_2020;
        apply_inputs();
        run_slot(ow);
        chk("both_first", 32'(ow), 0);
        run_slot(ow);
        chk("both_second", 32'(ow), 1);
        chk("both_gap", 32'(last_ready_cycle[1] - last_ready_cycle[0]), 3);

        // p1 byte write then word read back
        pend[1] = 1'b1; wr[1] = 1'b1; fmt[1] = 3'b000; addr[1] = 32'h0000_2003; wd[1] = 32'h0000_005A;
        apply_inputs();
        run_slot(ow);
        chk("byte_wr_winner", 32'(ow), 1);
        pend[1] = 1'b1; wr[1] = 1'b0; fmt[1] = 3'b010; addr[1] = 32'h0000_2000; wd[1] = '0;
        apply_inputs();
        run_slot(ow);
        chk("byte_rd_lane3", 32'(p1_rdata[31:24]), 32'h5A);

        // Starvation: p0 always requesting, p1 waiting
        for (int i = 0; i < 10; i++) begin
            for (int p = 0; p < 2; p++) if (!pend[p]) new_txn(p);
            apply_inputs();
            run_slot(ow);
            chk("starve_seq", 32'(ow), 32'(exp_seq[i]));
        end
        drain();

        // Reset during ACCESS discards the transaction
        pend[0] = 1'b1; wr[0] = 1'b0; fmt[0] = 3'b010; addr[0] = 32'h0000_2008;
        apply_inputs();
        @(negedge clock);
        chk("pre_rst_access", mem_read_enable, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        pend[0] = 1'b0;
        apply_inputs();
        exp_rdata[0] = '0; exp_rdata[1] = '0; ref_cnt = 0;
        chk("midrst_ready", {p1_ready, p0_ready}, 0);
        chk("midrst_enables", {mem_write_enable, mem_read_enable}, 0);
        chk("midrst_rdata", p0_rdata | p1_rdata, 0);
        chk("midrst_mem_addr", mem_address, 0);
        chk("midrst_mem_fmt_wdata", mem_wdata | 32'(mem_format), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("midrst_no_ready", {p1_ready, p0_ready}, 0);
        end

`ifdef DATA_ARB_RANGE_CHECK_EN
        // Out-of-window address: no memory access, error with ready
        pend[1] = 1'b1; wr[1] = 1'b0; fmt[1] = 3'b010; addr[1] = 32'hFFFF_0000;
        apply_inputs();
        @(negedge clock);
        chk("range_access_en", {mem_write_enable, mem_read_enable}, 0);
        @(negedge clock);
        chk("range_resp_en", {mem_write_enable, mem_read_enable}, 0);
        chk("range_ready", p1_ready, 1);
        chk("range_error", p1_error, 1);
        chk("range_rdata_held", p1_rdata, exp_rdata[1]);
        pend[1] = 1'b0;
        ref_cnt = 0;
        apply_inputs();
        @(negedge clock);
`endif

        // Random traffic
        for (int t = 0; t < 150; t++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 9) < 6) new_txn(p);
            apply_inputs();
            run_slot(ow);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
